stream_mux_2x1_rr: RTL and testbench

- Merges two valid/ready input streams (ch0, ch1) into one output stream.
- It is the merging counterpart of the 1x2 demux: the demux steers one source to one of two sinks; this block selects one of two sources onto one sink.
- Arbitration is round-robin with packet locking on a `last` flag, and the output has one register stage.
- Sits in front of any shared single-port consumer.

---
 rtl/stream_mux_2x1_rr.sv | 116 +++++++++++
 tb/tb_stream_mux_2x1_rr.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_mux_2x1_rr.sv
// stream_mux_2x1_rr
// Merges two valid/ready streams onto one registered output stream.
// New packets are picked round-robin; once a packet starts, its channel
// keeps the grant until the beat flagged `last` has been transferred.
// Output stage: a single register slot that can be refilled in the same
// cycle as it is drained, so one beat per cycle is sustained while yr=1.

module stream_mux_2x1_rr #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d0,
    input  logic         v0,
    input  logic         l0,
    output logic         r0,
    input  logic [W-1:0] d1,
    input  logic         v1,
    input  logic         l1,
    output logic         r1,
    output logic [W-1:0] y,
    output logic         yv,
    output logic         yl,
    output logic         ys,
    input  logic         yr
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    state_t       state;
    logic         lw;        // channel that finished the most recent packet
    logic         gv;        // a grant is active this cycle
    logic         gs;        // granted channel index
    logic         can_load;  // output slot is empty or being drained
    logic         xfer0;
    logic         xfer1;
    logic         xfer;
    logic [W-1:0] xd;
    logic         xl;

    // Grant selection: free arbitration in IDLE, fixed grant while locked.
    always_comb begin
        // NOTE: every output of this block gets a default first so that no
        // path through the case leaves it unassigned, which would infer a latch.
        gv = 1'b0;
        gs = 1'b0;
        case (state)
            IDLE: begin
                if (en && (v0 || v1)) begin
                    gv = 1'b1;
                    // On a tie, the channel that did not win last time goes.
                    gs = (v0 && v1) ? ~lw : v1;
                end
            end
            LOCK0: begin
                gv = 1'b1;
                gs = 1'b0;
            end
            LOCK1: begin
                gv = 1'b1;
                gs = 1'b1;
            end
            default: begin
                gv = 1'b0;
                gs = 1'b0;
            end
        endcase
    end

    assign can_load = ~yv | yr;

    // Ready is held low during reset so no beat is taken by a discarded state.
    assign r0 = gv & ~gs & can_load & ~rst;
    assign r1 = gv &  gs & can_load & ~rst;

    assign xfer0 = v0 & r0;
    assign xfer1 = v1 & r1;
    assign xfer  = xfer0 | xfer1;
    assign xd    = xfer1 ? d1 : d0;
    assign xl    = xfer1 ? l1 : l0;

    // Arbitration state, last-winner pointer and the output register slot.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples the values from before this clock edge.
        if (rst) begin
            state <= IDLE;
            lw    <= 1'b1;
            y     <= '0;
            yv    <= 1'b0;
            yl    <= 1'b0;
            ys    <= 1'b0;
        end else begin
            if (xfer) begin
                y  <= xd;
                yl <= xl;
                ys <= xfer1;
                yv <= 1'b1;
                if (xl) begin
                    state <= IDLE;
                    lw    <= xfer1;
                end else begin
                    state <= xfer1 ? LOCK1 : LOCK0;
                end
            end else if (yv && yr) begin
                yv <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stream_mux_2x1_rr.sv
// Testbench for stream_mux_2x1_rr.
// A packet-level reference model predicts which channel is granted each
// cycle and pushes every accepted input beat into a scoreboard queue; an
// independent monitor pops that queue whenever the sink accepts an output
// beat and compares data, last and source index.

module tb_stream_mux_2x1_rr;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] d;
        logic         l;
        logic         s;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en  = 1'b1;
    logic [W-1:0] d0  = '0;
    logic         v0  = 1'b0;
    logic         l0  = 1'b0;
    logic         r0;
    logic [W-1:0] d1  = '0;
    logic         v1  = 1'b0;
    logic         l1  = 1'b0;
    logic         r1;
    logic [W-1:0] y;
    logic         yv;
    logic         yl;
    logic         ys;
    logic         yr  = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    beat_t sb[$];

    // Reference model state: owner of the packet in progress (-1 = none),
    // channel that finished the last packet, and whether the output slot holds a beat.
    int owner = -1;
    bit m_lw  = 1'b1;
    bit m_yv  = 1'b0;

    // Handshakes seen at the most recent edge, used to advance the sources.
    bit t0;
    bit t1;

    stream_mux_2x1_rr #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .d0  (d0),
        .v0  (v0),
        .l0  (l0),
        .r0  (r0),
        .d1  (d1),
        .v1  (v1),
        .l1  (l1),
        .r1  (r1),
        .y   (y),
        .yv  (yv),
        .yl  (yl),
        .ys  (ys),
        .yr  (yr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one clock; inputs may be changed right after the return.
    task automatic step();
        @(negedge clk);
        t0 = v0 && r0;
        t1 = v1 && r1;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        v0  = 1'b0;
        v1  = 1'b0;
        l0  = 1'b0;
        l1  = 1'b0;
        en  = 1'b1;
        yr  = 1'b1;
        step();
        check("rst_r0", r0, 1'b0);
        check("rst_r1", r1, 1'b0);
        step();
        check("rst_y",  y,  8'h00);
        check("rst_yv", yv, 1'b0);
        check("rst_yl", yl, 1'b0);
        check("rst_ys", ys, 1'b0);
        rst = 1'b0;
    endtask

    // Reference model: grant from packet ownership and round-robin rules,
    // readiness from the model's own view of the output slot.
    always @(negedge clk) begin
        int  g;
        int  k;
        bit  slot_free;
        bit  er0;
        bit  er1;
        beat_t b;
        if (!rst) check("yv", yv, m_yv);
        g = -1;
        if (!rst) begin
            if (owner >= 0)   g = owner;
            else if (en) begin
                if (v0 && v1) g = m_lw ? 0 : 1;
                else if (v0)  g = 0;
                else if (v1)  g = 1;
            end
        end
        slot_free = !m_yv || yr;
        er0 = (g == 0) && slot_free;
        er1 = (g == 1) && slot_free;
        check("r0", r0, er0);
        check("r1", r1, er1);
        if (rst) begin
            owner = -1;
            m_lw  = 1'b1;
            m_yv  = 1'b0;
        end else if ((v0 && er0) || (v1 && er1)) begin
            k   = er1 ? 1 : 0;
            b.d = (k == 1) ? d1 : d0;
            b.l = (k == 1) ? l1 : l0;
            b.s = (k == 1);
            sb.push_back(b);
            m_yv = 1'b1;
            if (b.l) begin
                owner = -1;
                m_lw  = b.s;
            end else begin
                owner = k;
            end
        end else if (m_yv && yr) begin
            m_yv = 1'b0;
        end
    end

    // A reset discards whatever is in flight on the output side.
    always @(posedge clk) begin
        if (rst) sb.delete();
    end

    // Monitor: every beat accepted by the sink must match the scoreboard head.
    always @(negedge clk) begin
        beat_t e;
        if (!rst && yv === 1'b1 && yr) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("y",  y,  e.d);
                check("yl", yl, e.l);
                check("ys", ys, e.s);
            end
        end
    end

    initial begin
        logic [W-1:0] tie_d [4];
        logic         tie_s [4];
        tie_d = '{8'h10, 8'h20, 8'h10, 8'h20};
        tie_s = '{1'b0, 1'b1, 1'b0, 1'b1};

        // Single beat after reset.
        do_reset();
        v0 = 1'b1; d0 = 8'hA5; l0 = 1'b1; yr = 1'b1;
        step();
        v0 = 1'b0;
        check("single_y",  y,  8'hA5);
        check("single_yv", yv, 1'b1);
        check("single_yl", yl, 1'b1);
        check("single_ys", ys, 1'b0);
        step();
        check("single_drain_yv", yv, 1'b0);

        // Tie: alternate between channels, one beat per cycle.
        do_reset();
        v0 = 1'b1; d0 = 8'h10; l0 = 1'b1;
        v1 = 1'b1; d1 = 8'h20; l1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("tie_y",  y,  tie_d[i]);
            check("tie_ys", ys, tie_s[i]);
            check("tie_yv", yv, 1'b1);
        end

        // Packet lock: ch1 waits for the whole ch0 packet.
        do_reset();
        v1 = 1'b1; d1 = 8'hFF; l1 = 1'b1;
        v0 = 1'b1; d0 = 8'h01; l0 = 1'b0;
        step();
        check("lock_y1", y, 8'h01);
        check("lock_r1", r1, 1'b0);
        d0 = 8'h02;
        step();
        check("lock_y2", y, 8'h02);
        d0 = 8'h03; l0 = 1'b1;
        step();
        check("lock_y3", y, 8'h03);
        check("lock_yl", yl, 1'b1);
        v0 = 1'b0;
        step();
        check("lock_yff", y, 8'hFF);
        check("lock_ys",  ys, 1'b1);
        v1 = 1'b0;

        // Backpressure: output holds while stalled, then refills on accept.
        do_reset();
        yr = 1'b0;
        v0 = 1'b1; d0 = 8'h42; l0 = 1'b1;
        step();
        d0 = 8'h43;
        for (int i = 0; i < 4; i++) begin
            check("bp_y",  y,  8'h42);
            check("bp_yv", yv, 1'b1);
            check("bp_r0", r0, 1'b0);
            step();
        end
        yr = 1'b1;
        step();
        check("bp_refill_y",  y,  8'h43);
        check("bp_refill_yv", yv, 1'b1);
        v0 = 1'b0;
        step();
        check("bp_empty_yv", yv, 1'b0);

        // en gating: no new packet while en=0, but a started packet finishes.
        do_reset();
        en = 1'b0;
        v1 = 1'b1; d1 = 8'h77; l1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("en_r1", r1, 1'b0);
            step();
            check("en_yv", yv, 1'b0);
        end
        v1 = 1'b0; en = 1'b1;
        v0 = 1'b1; d0 = 8'hB1; l0 = 1'b0;
        step();
        check("en_b1", y, 8'hB1);
        en = 1'b0; d0 = 8'hB2; l0 = 1'b1;
        step();
        check("en_b2", y, 8'hB2);
        d0 = 8'hB3;
        step();
        check("en_hold_yv1", yv, 1'b0);
        step();
        check("en_hold_yv2", yv, 1'b0);
        en = 1'b1;
        step();
        check("en_b3", y, 8'hB3);
        v0 = 1'b0;

        // Reset in the middle of a ch1 packet.
        do_reset();
        v1 = 1'b1; d1 = 8'hC1; l1 = 1'b0;
        step();
        check("midrst_y",  y,  8'hC1);
        check("midrst_ys", ys, 1'b1);
        rst = 1'b1;
        step();
        check("midrst_yv", yv, 1'b0);
        rst = 1'b0;
        v0 = 1'b1; d0 = 8'hD0; l0 = 1'b1;
        v1 = 1'b1; d1 = 8'hC2; l1 = 1'b1;
        step();
        check("midrst_first_ys", ys, 1'b0);
        check("midrst_first_y",  y,  8'hD0);

        // Randomized traffic; sources advance to a fresh beat after each handshake.
        for (int c = 0; c < 3000; c++) begin
            step();
            if (t0) begin
                d0 = W'($urandom);
                l0 = ($urandom_range(0, 2) == 0);
            end
            if (t1) begin
                d1 = W'($urandom);
                l1 = ($urandom_range(0, 2) == 0);
            end
            v0  = ($urandom_range(0, 9) < 6);
            v1  = ($urandom_range(0, 9) < 6);
            en  = ($urandom_range(0, 9) != 0);
            yr  = ($urandom_range(0, 9) < 7);
            rst = ($urandom_range(0, 199) == 0);
        end

        // Drain: every beat that entered must have left.
        rst = 1'b0; v0 = 1'b0; v1 = 1'b0; yr = 1'b1;
        repeat (4) step();
        check("drain", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
